// File: rtl/datasel_pkg.sv
// Shared constants and helpers for the datasel_rr data selector.
package datasel_pkg;

  localparam logic DSEL_MODE_DIRECT = 1'b0;
  localparam logic DSEL_MODE_RR     = 1'b1;

  // Smallest r such that 2**r >= n; sizes the channel index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/datasel_rr_if.sv
// Channel-side and output-side handshake bundle of datasel_rr.
// DATASEL_PARITY_EN adds the registered parity output yparout.
interface datasel_rr_if
  import datasel_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) ();

  localparam int SW = clog2(N);

  logic            gbin;
  logic            modein;
  logic [SW-1:0]   selin;
  logic [N-1:0]    cvalidin;
  logic [N*W-1:0]  cdatain;
  logic [N-1:0]    creadyout;
  logic            yvalidout;
  logic [W-1:0]    ydataout;
  logic [SW-1:0]   ychanout;
  logic            yreadyin;
`ifdef DATASEL_PARITY_EN
  logic            yparout;

  modport master (
    output gbin, modein, selin, cvalidin, cdatain, yreadyin,
    input  creadyout, yvalidout, ydataout, ychanout, yparout
  );
  modport slave (
    input  gbin, modein, selin, cvalidin, cdatain, yreadyin,
    output creadyout, yvalidout, ydataout, ychanout, yparout
  );
`else
  modport master (
    output gbin, modein, selin, cvalidin, cdatain, yreadyin,
    input  creadyout, yvalidout, ydataout, ychanout
  );
  modport slave (
    input  gbin, modein, selin, cvalidin, cdatain, yreadyin,
    output creadyout, yvalidout, ydataout, ychanout
  );
`endif

endinterface

// File: rtl/datasel_rr_arb.sv
// Round-robin arbiter: searches from pointer+1 upward (mod N) and owns the pointer,
// which moves to whatever channel actually transferred, in either mode.
module datasel_rr_arb
  import datasel_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clkin,
  input  logic                rstin,
  input  logic [N-1:0]        req,
  input  logic                adv,
  input  logic [clog2(N)-1:0] adv_idx,
  output logic [N-1:0]        gnt,
  output logic [clog2(N)-1:0] idx
);

  localparam int SW = clog2(N);

  logic [SW-1:0] ptr_reg;
  logic [SW-1:0] cand;
  logic          found;

  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      ptr_reg <= SW'(N - 1);
    end else if (adv) begin
      ptr_reg <= adv_idx;
    end
  end

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = SW'((int'(ptr_reg) + k) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/datasel_rr.sv
// N-channel registered data selector, direct or round-robin, with gate mask.
// Optional build macro DATASEL_PARITY_EN adds registered even parity (yparout).
module datasel_rr
  import datasel_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic         clkin,
  input  logic         rstin,
  datasel_rr_if.slave  bus
);

  localparam int SW = clog2(N);

  logic [W-1:0]  chan_data [N];
  logic [N-1:0]  dir_gnt;
  logic [N-1:0]  rr_gnt;
  logic [SW-1:0] rr_idx;
  logic [N-1:0]  gnt;
  logic [SW-1:0] gidx;
  logic          ld;
  logic          xfer;
  logic          valid_reg;
  logic [W-1:0]  data_reg;
  logic [SW-1:0] chan_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_split
      assign chan_data[gi] = bus.cdatain[gi*W +: W];
    end
  endgenerate

  always_comb begin
    dir_gnt = '0;
    if (bus.modein == DSEL_MODE_DIRECT && int'(bus.selin) < N) begin
      dir_gnt[bus.selin] = bus.cvalidin[bus.selin];
    end
  end

  datasel_rr_arb #(.N(N)) u_arb (
    .clkin   (clkin),
    .rstin   (rstin),
    .req     (bus.cvalidin),
    .adv     (xfer),
    .adv_idx (gidx),
    .gnt     (rr_gnt),
    .idx     (rr_idx)
  );

  assign gnt  = (bus.modein == DSEL_MODE_RR) ? rr_gnt : dir_gnt;
  assign gidx = (bus.modein == DSEL_MODE_RR) ? rr_idx : bus.selin;

  // Load when the slot is free or being drained this cycle; reset masks accepts.
  assign ld             = ~bus.gbin & (~valid_reg | bus.yreadyin);
  assign bus.creadyout  = gnt & {N{ld & ~rstin}};
  assign xfer           = |(bus.creadyout & bus.cvalidin);

  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      chan_reg  <= '0;
    end else if (xfer) begin
      valid_reg <= 1'b1;
      data_reg  <= chan_data[gidx];
      chan_reg  <= gidx;
    end else if (valid_reg & bus.yreadyin & ~bus.gbin) begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.yvalidout = valid_reg & ~bus.gbin;
  assign bus.ydataout  = bus.gbin ? '0 : data_reg;
  assign bus.ychanout  = bus.gbin ? '0 : chan_reg;

`ifdef DATASEL_PARITY_EN
  logic par_reg;

  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      par_reg <= 1'b0;
    end else if (xfer) begin
      par_reg <= ^chan_data[gidx];
    end
  end

  assign bus.yparout = bus.gbin ? 1'b0 : par_reg;
`endif

endmodule

// File: tb/tb_datasel_rr.sv
// Self-checking bench for datasel_rr: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_datasel_rr;
  import datasel_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = clog2(N);

  logic clkin = 1'b0;
  logic rstin = 1'b1;
  always #5 clkin = ~clkin;

  datasel_rr_if #(.N(N), .W(W)) bus ();

  datasel_rr #(.N(N), .W(W)) dut (
    .clkin (clkin),
    .rstin (rstin),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] data_v [N];

  task automatic apply_data();
    for (int i = 0; i < N; i++) bus.cdatain[i*W +: W] = data_v[i];
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) data_v[i] = $urandom;
    apply_data();
  endtask

  task automatic drive(input logic g, input logic m, input logic [SW-1:0] s,
                       input logic [N-1:0] v, input logic r);
    bus.gbin     = g;
    bus.modein   = m;
    bus.selin    = s;
    bus.cvalidin = v;
    bus.yreadyin = r;
  endtask

  task automatic do_reset();
    @(negedge clkin);
    rstin = 1'b1;
    drive(1'b0, DSEL_MODE_DIRECT, '0, '0, 1'b1);
    @(negedge clkin);
    rstin = 1'b0;
  endtask

  // Reference grant derived directly from the selection rules.
  function automatic logic [N-1:0] ref_grant(input logic m, input int s,
                                              input logic [N-1:0] v, input int ptr);
    logic [N-1:0] g;
    g = '0;
    if (m == DSEL_MODE_DIRECT) begin
      if (s < N && v[s]) g[s] = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (v[c]) begin
          g[c] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic test_reset();
    @(negedge clkin);
    rand_data();
    drive(1'b0, DSEL_MODE_DIRECT, '0, 4'b1111, 1'b1);
    #1;
    n_checks++; if (bus.creadyout !== 4'b0000) begin n_fail++; $display("FAIL reset_cready: got %b want 0000", bus.creadyout); end
    n_checks++; if (bus.yvalidout !== 1'b0) begin n_fail++; $display("FAIL reset_yvalid: got %b want 0", bus.yvalidout); end
    n_checks++; if (bus.ydataout !== '0) begin n_fail++; $display("FAIL reset_ydata: got %h want 0", bus.ydataout); end
    n_checks++; if (bus.ychanout !== '0) begin n_fail++; $display("FAIL reset_ychan: got %0d want 0", bus.ychanout); end
    @(posedge clkin); #1;
    n_checks++; if (bus.yvalidout !== 1'b0) begin n_fail++; $display("FAIL reset_hold_yvalid: got %b want 0", bus.yvalidout); end
    @(negedge clkin);
    rstin = 1'b0;
    drive(1'b0, DSEL_MODE_DIRECT, '0, '0, 1'b1);
    $display("reset: released");
  endtask

  task automatic test_direct();
    @(negedge clkin);
    rand_data();
    data_v[2] = 32'hA5A5_0002;
    apply_data();
    drive(1'b0, DSEL_MODE_DIRECT, 2'd2, 4'b0100, 1'b1);
    #1;
    n_checks++; if (bus.creadyout !== 4'b0100) begin n_fail++; $display("FAIL direct_cready: got %b want 0100", bus.creadyout); end
    @(posedge clkin); #1;
    n_checks++; if (bus.yvalidout !== 1'b1) begin n_fail++; $display("FAIL direct_yvalid: got %b want 1", bus.yvalidout); end
    n_checks++; if (bus.ydataout !== 32'hA5A5_0002) begin n_fail++; $display("FAIL direct_ydata: got %h want a5a50002", bus.ydataout); end
    n_checks++; if (bus.ychanout !== 2'd2) begin n_fail++; $display("FAIL direct_ychan: got %0d want 2", bus.ychanout); end
    $display("direct: ch=%0d data=%h", bus.ychanout, bus.ydataout);
  endtask

  task automatic test_rr_fairness();
    logic [N-1:0] expv;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clkin);
      rand_data();
      drive(1'b0, DSEL_MODE_RR, '0, 4'b1111, 1'b1);
      expv = 4'b0001 << (i % N);
      #1;
      n_checks++; if (bus.creadyout !== expv) begin n_fail++; $display("FAIL rr_cready[%0d]: got %b want %b", i, bus.creadyout, expv); end
      @(posedge clkin); #1;
      n_checks++; if (bus.yvalidout !== 1'b1) begin n_fail++; $display("FAIL rr_yvalid[%0d]: got %b want 1", i, bus.yvalidout); end
      n_checks++; if (int'(bus.ychanout) !== (i % N)) begin n_fail++; $display("FAIL rr_ychan[%0d]: got %0d want %0d", i, bus.ychanout, i % N); end
      n_checks++; if (bus.ydataout !== data_v[i % N]) begin n_fail++; $display("FAIL rr_ydata[%0d]: got %h want %h", i, bus.ydataout, data_v[i % N]); end
      $display("rr: ch=%0d data=%h", bus.ychanout, bus.ydataout);
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] held;
    held = data_v[3];
    for (int i = 0; i < 2; i++) begin
      @(negedge clkin);
      rand_data();
      drive(1'b0, DSEL_MODE_RR, '0, 4'b1111, 1'b0);
      #1;
      n_checks++; if (bus.creadyout !== 4'b0000) begin n_fail++; $display("FAIL bp_cready[%0d]: got %b want 0000", i, bus.creadyout); end
      n_checks++; if (bus.ydataout !== held) begin n_fail++; $display("FAIL bp_ydata[%0d]: got %h want %h", i, bus.ydataout, held); end
      n_checks++; if (bus.yvalidout !== 1'b1) begin n_fail++; $display("FAIL bp_yvalid[%0d]: got %b want 1", i, bus.yvalidout); end
    end
    @(negedge clkin);
    rand_data();
    drive(1'b0, DSEL_MODE_RR, '0, 4'b0010, 1'b1);
    #1;
    n_checks++; if (bus.creadyout !== 4'b0010) begin n_fail++; $display("FAIL bp_reload_cready: got %b want 0010", bus.creadyout); end
    @(posedge clkin); #1;
    n_checks++; if (bus.yvalidout !== 1'b1) begin n_fail++; $display("FAIL bp_reload_yvalid: got %b want 1", bus.yvalidout); end
    n_checks++; if (bus.ychanout !== 2'd1) begin n_fail++; $display("FAIL bp_reload_ychan: got %0d want 1", bus.ychanout); end
    n_checks++; if (bus.ydataout !== data_v[1]) begin n_fail++; $display("FAIL bp_reload_ydata: got %h want %h", bus.ydataout, data_v[1]); end
    $display("back_pressure: reload ch=%0d data=%h", bus.ychanout, bus.ydataout);
  endtask

  task automatic test_gate();
    @(negedge clkin);
    rand_data();
    data_v[0] = 32'h1234_5678;
    apply_data();
    drive(1'b0, DSEL_MODE_DIRECT, 2'd0, 4'b0001, 1'b1);
    @(posedge clkin); #1;
    n_checks++; if (bus.ydataout !== 32'h1234_5678) begin n_fail++; $display("FAIL gate_load: got %h want 12345678", bus.ydataout); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clkin);
      drive(1'b1, DSEL_MODE_RR, '0, 4'b1111, 1'b1);
      #1;
      n_checks++; if (bus.ydataout !== '0) begin n_fail++; $display("FAIL gate_ydata[%0d]: got %h want 0", i, bus.ydataout); end
      n_checks++; if (bus.yvalidout !== 1'b0) begin n_fail++; $display("FAIL gate_yvalid[%0d]: got %b want 0", i, bus.yvalidout); end
      n_checks++; if (bus.ychanout !== '0) begin n_fail++; $display("FAIL gate_ychan[%0d]: got %0d want 0", i, bus.ychanout); end
      n_checks++; if (bus.creadyout !== 4'b0000) begin n_fail++; $display("FAIL gate_cready[%0d]: got %b want 0000", i, bus.creadyout); end
    end
    @(negedge clkin);
    drive(1'b0, DSEL_MODE_DIRECT, '0, 4'b0000, 1'b0);
    #1;
    n_checks++; if (bus.ydataout !== 32'h1234_5678) begin n_fail++; $display("FAIL gate_return_ydata: got %h want 12345678", bus.ydataout); end
    n_checks++; if (bus.yvalidout !== 1'b1) begin n_fail++; $display("FAIL gate_return_yvalid: got %b want 1", bus.yvalidout); end
    @(negedge clkin);
    drive(1'b0, DSEL_MODE_RR, '0, 4'b1111, 1'b1);
    #1;
    n_checks++; if (bus.creadyout !== 4'b0010) begin n_fail++; $display("FAIL gate_ptr_cready: got %b want 0010", bus.creadyout); end
    @(posedge clkin); #1;
    n_checks++; if (bus.ychanout !== 2'd1) begin n_fail++; $display("FAIL gate_ptr_ychan: got %0d want 1", bus.ychanout); end
    $display("gate: after release ch=%0d data=%h", bus.ychanout, bus.ydataout);
  endtask

  task automatic test_edge();
    @(negedge clkin);
    rand_data();
    drive(1'b0, DSEL_MODE_DIRECT, 2'd3, 4'b0111, 1'b1);
    #1;
    n_checks++; if (bus.creadyout !== 4'b0000) begin n_fail++; $display("FAIL edge_sel3_cready: got %b want 0000", bus.creadyout); end
    @(posedge clkin); #1;
    n_checks++; if (bus.yvalidout !== 1'b0) begin n_fail++; $display("FAIL edge_drain_yvalid: got %b want 0", bus.yvalidout); end
    @(negedge clkin);
    rand_data();
    drive(1'b0, DSEL_MODE_DIRECT, 2'd1, 4'b0010, 1'b1);
    @(negedge clkin);
    drive(1'b0, DSEL_MODE_RR, '0, 4'b1111, 1'b0);
    #1;
    n_checks++; if (bus.yvalidout !== 1'b1) begin n_fail++; $display("FAIL edge_stall_yvalid: got %b want 1", bus.yvalidout); end
    rstin = 1'b1;
    #1;
    n_checks++; if (bus.yvalidout !== 1'b0) begin n_fail++; $display("FAIL edge_arst_yvalid: got %b want 0", bus.yvalidout); end
    n_checks++; if (bus.ydataout !== '0) begin n_fail++; $display("FAIL edge_arst_ydata: got %h want 0", bus.ydataout); end
    n_checks++; if (bus.ychanout !== '0) begin n_fail++; $display("FAIL edge_arst_ychan: got %0d want 0", bus.ychanout); end
    n_checks++; if (bus.creadyout !== 4'b0000) begin n_fail++; $display("FAIL edge_arst_cready: got %b want 0000", bus.creadyout); end
    @(negedge clkin);
    rstin = 1'b0;
    drive(1'b0, DSEL_MODE_RR, '0, 4'b1111, 1'b1);
    #1;
    n_checks++; if (bus.creadyout !== 4'b0001) begin n_fail++; $display("FAIL edge_restart_cready: got %b want 0001", bus.creadyout); end
    $display("edge: restart grant=%b", bus.creadyout);
  endtask

`ifdef DATASEL_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] pv [2];
    logic         pe [2];
    pv[0] = 32'h0000_0007; pe[0] = 1'b1;
    pv[1] = 32'h0000_0003; pe[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clkin);
      data_v[0] = pv[i];
      apply_data();
      drive(1'b0, DSEL_MODE_DIRECT, 2'd0, 4'b0001, 1'b1);
      @(posedge clkin); #1;
      n_checks++; if (bus.yparout !== pe[i]) begin n_fail++; $display("FAIL parity[%0d]: got %b want %b", i, bus.yparout, pe[i]); end
      $display("parity: data=%h par=%b", bus.ydataout, bus.yparout);
    end
  endtask
`endif

  task automatic test_random();
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_chan;
    int           m_ptr;
    logic         g, m, r, ld;
    logic [SW-1:0] s;
    logic [N-1:0] v, eg;
    do_reset();
    m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = N - 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clkin);
      rand_data();
      g = ($urandom_range(0, 9) == 0);
      m = 1'($urandom_range(0, 1));
      s = SW'($urandom_range(0, N - 1));
      v = N'($urandom);
      r = ($urandom_range(0, 3) != 0);
      drive(g, m, s, v, r);
      ld = !g && (!m_valid || r);
      eg = ld ? ref_grant(m, int'(s), v, m_ptr) : '0;
      #1;
      n_checks++; if (bus.creadyout !== eg) begin n_fail++; $display("FAIL rand_cready[%0d]: got %b want %b", cyc, bus.creadyout, eg); end
      n_checks++; if (bus.yvalidout !== (m_valid && !g)) begin n_fail++; $display("FAIL rand_yvalid[%0d]: got %b want %b", cyc, bus.yvalidout, m_valid && !g); end
      n_checks++; if (bus.ydataout !== (g ? '0 : m_data)) begin n_fail++; $display("FAIL rand_ydata[%0d]: got %h want %h", cyc, bus.ydataout, g ? '0 : m_data); end
      n_checks++; if (int'(bus.ychanout) !== (g ? 0 : m_chan)) begin n_fail++; $display("FAIL rand_ychan[%0d]: got %0d want %0d", cyc, bus.ychanout, g ? 0 : m_chan); end
`ifdef DATASEL_PARITY_EN
      n_checks++; if (bus.yparout !== (g ? 1'b0 : ^m_data)) begin n_fail++; $display("FAIL rand_ypar[%0d]: got %b want %b", cyc, bus.yparout, g ? 1'b0 : ^m_data); end
`endif
      if (eg != '0) begin
        for (int i = 0; i < N; i++) begin
          if (eg[i]) begin
            m_valid = 1'b1; m_data = data_v[i]; m_chan = i; m_ptr = i;
          end
        end
        $display("rand[%0d]: xfer ch=%0d data=%h mode=%b", cyc, m_chan, m_data, m);
      end else if (m_valid && r && !g) begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) data_v[i] = '0;
    apply_data();
    drive(1'b0, DSEL_MODE_DIRECT, '0, '0, 1'b0);
    test_reset();
    test_direct();
    test_rr_fairness();
    test_back_pressure();
    test_gate();
    test_edge();
`ifdef DATASEL_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
